// File: rtl/simd_alu_pipe_if.sv
// Handshake and data bundle for simd_alu_pipe: register-file side in, writeback side out.
interface simd_alu_pipe_if #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int ACC_W  = 24
);
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               aluctrl;
  logic                     acc_clr;
  logic [LANES*LANE_W-1:0]  a;
  logic [LANES*LANE_W-1:0]  b;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*LANE_W-1:0]  c;
  logic [LANES*ACC_W-1:0]   acc;

  // master drives transactions and the downstream ready
  modport master (
    output in_valid, aluctrl, acc_clr, a, b, out_ready,
    input  in_ready, out_valid, c, acc
  );

  // slave is the ALU pipe itself
  modport slave (
    input  in_valid, aluctrl, acc_clr, a, b, out_ready,
    output in_ready, out_valid, c, acc
  );
endinterface

// File: rtl/simd_alu_pipe.sv
// Two-stage SIMD ALU: S1 registers the request, S2 registers per-lane results.
// Per-lane accumulators live alongside S2 and are what the acc output shows.

// One lane of combinational ALU; evaluated on the S1 contents.
module simd_alu_lane #(
  parameter int LANE_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic [3:0]        op,
  input  logic              clr,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [ACC_W-1:0]  acc_cur,
  output logic [LANE_W-1:0] c,
  output logic [ACC_W-1:0]  acc_nxt
);
  localparam logic [LANE_W:0] LW = LANE_W;

  logic [LANE_W:0]   sum;
  logic [2*LANE_W-1:0] prod;
  logic [ACC_W-1:0]  mac;
  logic              big_sh;

  // Lane result select; shifts by LANE_W or more flush to zero explicitly.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    prod   = (2*LANE_W)'(a) * (2*LANE_W)'(b);
    mac    = (clr ? '0 : acc_cur) + ACC_W'(prod);
    big_sh = ({1'b0, b} >= LW);
    acc_nxt = (op == 4'd12) ? mac : acc_cur;
    case (op)
      4'd0:    c = sum[LANE_W-1:0];
      4'd1:    c = a - b;
      4'd2:    c = prod[LANE_W-1:0];
      4'd3:    c = a | b;
      4'd4:    c = a & b;
      4'd5:    c = a ^ b;
      4'd6:    c = big_sh ? '0 : (a << b);
      4'd7:    c = big_sh ? '0 : (a >> b);
      4'd8:    c = sum[LANE_W] ? '1 : sum[LANE_W-1:0];
      4'd9:    c = (a < b) ? '0 : (a - b);
      4'd10:   c = (a < b) ? a : b;
      4'd11:   c = (a < b) ? b : a;
      4'd12:   c = mac[LANE_W-1:0];
      default: c = '0;
    endcase
  end
endmodule

module simd_alu_pipe #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  simd_alu_pipe_if.slave bus
);
  typedef struct packed {
    logic [3:0]                   op;
    logic                         clr;
    logic [LANES-1:0][LANE_W-1:0] a;
    logic [LANES-1:0][LANE_W-1:0] b;
  } s1_t;

  s1_t                          req, s1_q;
  logic                         s1_valid, s2_valid;
  logic                         s2_adv;
  logic [LANES-1:0][LANE_W-1:0] c_q, c_nxt;
  logic [LANES-1:0][ACC_W-1:0]  acc_q, acc_nxt;

  // Ready chain depends only on pipe state, never on in_valid.
  assign s2_adv       = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv;
  assign bus.out_valid = s2_valid;
  assign bus.c        = c_q;
  // acc_q only moves when S1 hands off to S2, so it is exactly S2's acc.
  assign bus.acc      = acc_q;

  // Pack the incoming request into the S1 layout.
  always_comb begin
    req     = '0;
    req.op  = bus.aluctrl;
    req.clr = bus.acc_clr;
    req.a   = bus.a;
    req.b   = bus.b;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    simd_alu_lane #(.LANE_W(LANE_W), .ACC_W(ACC_W)) u_lane (
      .op      (s1_q.op),
      .clr     (s1_q.clr),
      .a       (s1_q.a[i]),
      .b       (s1_q.b[i]),
      .acc_cur (acc_q[i]),
      .c       (c_nxt[i]),
      .acc_nxt (acc_nxt[i])
    );
  end

  // S1: load a new request whenever the stage is free or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_q <= req;
    end
  end

  // S2 + accumulators: update only on an actual S1->S2 hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      c_q      <= '0;
      acc_q    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        c_q   <= c_nxt;
        acc_q <= acc_nxt;
      end
    end
  end
endmodule

// File: tb/tb_simd_alu_pipe.sv
// Randomized + directed bench for simd_alu_pipe against a lane-arithmetic model.
module tb_simd_alu_pipe;
  localparam int LANES = 4, LANE_W = 8, ACC_W = 24;

  typedef struct {
    logic [31:0] c;
    logic [95:0] acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rnd;
  int   nvec = 0, nerr = 0;
  int   macc [LANES];
  exp_t expq [$];
  logic [31:0] last_c;
  logic [95:0] last_acc;

  simd_alu_pipe_if #(.LANES(LANES), .LANE_W(LANE_W), .ACC_W(ACC_W)) bus ();

  simd_alu_pipe #(.LANES(LANES), .LANE_W(LANE_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Lane-by-lane arithmetic straight from the op table; MAC state kept in macc.
  function automatic exp_t model(input logic [3:0] op, input logic clr,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int av, bv, r;
    for (int i = 0; i < LANES; i++) begin
      av = int'(a[i*8 +: 8]);
      bv = int'(b[i*8 +: 8]);
      r  = 0;
      case (op)
        4'd0:  r = (av + bv) % 256;
        4'd1:  r = (av - bv + 256) % 256;
        4'd2:  r = (av * bv) % 256;
        4'd3:  r = av | bv;
        4'd4:  r = av & bv;
        4'd5:  r = av ^ bv;
        4'd6:  r = (bv >= 8) ? 0 : ((av << bv) % 256);
        4'd7:  r = (bv >= 8) ? 0 : (av >> bv);
        4'd8:  r = (av + bv > 255) ? 255 : av + bv;
        4'd9:  r = (av > bv) ? av - bv : 0;
        4'd10: r = (av < bv) ? av : bv;
        4'd11: r = (av > bv) ? av : bv;
        4'd12: begin
          macc[i] = ((clr ? 0 : macc[i]) + av * bv) % (1 << 24);
          r = macc[i] % 256;
        end
        default: r = 0;
      endcase
      e.c[i*8 +: 8]    = 8'(r);
      e.acc[i*24 +: 24] = 24'(macc[i]);
    end
    return e;
  endfunction

  // Negedge monitor: result must match queue head every cycle it is valid; inputs accepted get modelled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        if (expq.size() == 0) chk("spurious_out", 1, 0);
        else begin
          chk("c", bus.c, expq[0].c);
          chk("acc", bus.acc, expq[0].acc);
          if (bus.out_ready) begin
            last_c   = bus.c;
            last_acc = bus.acc;
            void'(expq.pop_front());
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        expq.push_back(model(bus.aluctrl, bus.acc_clr, bus.a, bus.b));
    end
  end

  // Random downstream backpressure during the random phase.
  always @(posedge clk) begin
    if (rnd) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [3:0] op, input logic clr, input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.aluctrl  = op;
    bus.acc_clr  = clr;
    bus.a        = a;
    bus.b        = b;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk);
      #2;
      if (expq.size() == 0) done = 1;
    end
    if (!done) chk("drain_timeout", expq.size(), 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    rnd = 1'b0;
    bus.in_valid = 1'b0;
    bus.aluctrl = '0;
    bus.acc_clr = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b1;
    last_c = '0;
    last_acc = '0;
    for (int i = 0; i < LANES; i++) macc[i] = 0;

    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_c", bus.c, 0);
    chk("rst_acc", bus.acc, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency and lane-isolated wrap
    send(4'd0, 1'b0, 32'h01FF7F10, 32'h01010110);
    @(negedge clk); chk("lat_early", bus.out_valid, 0);
    @(negedge clk); chk("lat_2", bus.out_valid, 1);
    chk("op0_c", bus.c, 32'h02008020);
    wait_drain();

    send(4'd8, 1'b0, 32'hF0F00A00, 32'h20100500); wait_drain();
    chk("op8_sat", last_c, 32'hFFFF0F00);
    send(4'd9, 1'b0, 32'hF0F00A00, 32'h20100500); wait_drain();
    chk("op9_sub", last_c, 32'hD0E00500);
    send(4'd9, 1'b0, 32'h00000005, 32'h00000009); wait_drain();
    chk("op9_clamp", last_c, 32'h00000000);
    send(4'd6, 1'b0, 32'h01010101, 32'h08030001); wait_drain();
    chk("op6_shl", last_c, 32'h00080102);
    send(4'd7, 1'b0, 32'hFFFFFFFF, 32'h09090909); wait_drain();
    chk("op7_big", last_c, 32'h00000000);

    // Back-to-back MAC chain
    send(4'd12, 1'b1, 32'h10101010, 32'h10101010);
    send(4'd12, 1'b0, 32'h10101010, 32'h10101010);
    send(4'd12, 1'b0, 32'h10101010, 32'h10101010);
    send(4'd12, 1'b0, 32'h10101010, 32'h10101010);
    wait_drain();
    chk("mac4_acc", last_acc, 96'h000400_000400_000400_000400);
    chk("mac4_c", last_c, 32'h00000000);
    send(4'd12, 1'b1, 32'h03030303, 32'h03030303); wait_drain();
    chk("mac_clr_acc", last_acc, 96'h000009_000009_000009_000009);
    chk("mac_clr_c", last_c, 32'h09090909);

    // Backpressure: stall output 5 cycles while streaming 3 MACs
    bus.out_ready = 1'b0;
    fork
      begin
        send(4'd12, 1'b1, 32'h01010101, 32'h01010101);
        send(4'd12, 1'b0, 32'h01010101, 32'h01010101);
        send(4'd12, 1'b0, 32'h01010101, 32'h01010101);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk); chk("bp_in_ready", bus.in_ready, 0);
        @(posedge clk); #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_acc", last_acc, 96'h000003_000003_000003_000003);
    chk("bp_c", last_c, 32'h03030303);

    // Random stream with random backpressure
    rnd = 1'b1;
    repeat (300) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 1) == 1) rb = rb & 32'h0F0F0F0F;
      send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ra, rb);
    end
    rnd = 1'b0;
    #2 bus.out_ready = 1'b1;
    wait_drain();

    // Async reset with both stages full
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(4'd12, 1'b1, 32'h05050505, 32'h05050505);
    send(4'd12, 1'b0, 32'h05050505, 32'h05050505);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_c", bus.c, 0);
    chk("mid_rst_acc", bus.acc, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    expq.delete();
    for (int i = 0; i < LANES; i++) macc[i] = 0;
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    send(4'd12, 1'b0, 32'h02020202, 32'h02020202); wait_drain();
    chk("post_rst_acc", last_acc, 96'h000004_000004_000004_000004);
    chk("post_rst_c", last_c, 32'h04040404);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/simd_alu_pipe.md
Name: simd_alu_pipe

Overview:
Parametrised, pipelined successor to the team's 8-bit SIMD ALU. It processes LANES independent lanes of LANE_W bits per transaction and adds saturating, min/max and per-lane multiply-accumulate modes. It sits between the SIMD register-file read port and the writeback stage, with valid/ready handshakes on both sides so writeback can stall it.

Parameters:
LANES, 4, number of parallel lanes
LANE_W, 8, bits per lane operand and result
ACC_W, 24, bits per lane accumulator (must be >= 2*LANE_W)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream presents a transaction
in_ready  out  1  block accepts a transaction this cycle
aluctrl  in  4  operation select
acc_clr  in  1  MAC only: start a fresh accumulation (acc = a*b)
a  in  LANES*LANE_W  packed operand A, lane i = a[i*LANE_W +: LANE_W]
b  in  LANES*LANE_W  packed operand B, same packing
out_valid  out  1  result available
out_ready  in  1  downstream accepts the result
c  out  LANES*LANE_W  packed per-lane result
acc  out  LANES*ACC_W  packed per-lane accumulator value after this transaction

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Pipeline: two register stages. S1 holds {aluctrl, acc_clr, a, b}. S2 holds {c, acc}.
- Latency: an accepted transaction appears on out_valid exactly 2 cycles after acceptance when there is no stall. Throughput is 1 per cycle.
- Acceptance: a transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Stall logic: s2_adv = !s2_valid || out_ready. in_ready = !s1_valid || s2_adv. This is combinational, with no dependency on in_valid.
- Holding: while stalled, S1 and S2 contents and c/acc are held stable. out_valid is never dropped before it is accepted.
- Reset (async assert): s1_valid = s2_valid = 0, out_valid = 0, c = 0, acc = 0 in every lane, all S1 fields = 0. in_ready = 1 after reset. A mid-transaction reset discards in-flight data and clears accumulators.
- Ops, per lane, unsigned, results truncated to LANE_W unless stated:
  - 0: a+b (wraps)
  - 1: a-b (wraps)
  - 2: low LANE_W bits of a*b
  - 3: a|b
  - 4: a&b
  - 5: a^b
  - 6: a<<b; result 0 if b >= LANE_W
  - 7: a>>b (logical); result 0 if b >= LANE_W
  - 8: saturating add; clamp to 2^LANE_W-1
  - 9: saturating sub; clamp to 0
  - 10: min(a,b)
  - 11: max(a,b)
  - 12: MAC; acc_next = (acc_clr ? 0 : acc) + a*b, wrapping mod 2^ACC_W; c = low LANE_W bits of acc_next
  - 13-15: c = 0 in every lane, acc unchanged
- Accumulator:
  - Each lane accumulator is a persistent register, updated only when an op-12 transaction moves S1->S2. It changes exactly once per accepted MAC, never during stalls.
  - Non-MAC ops leave the accumulator unchanged. The acc output then shows the current accumulator value.
  - Back-to-back MACs chain correctly with no bubble: the S1->S2 update uses the freshly written accumulator.
- Lanes are fully independent. There is no carry, borrow or saturation interaction between lanes.
- Simultaneous events: when S2 drains (out_ready) and S1 advances in the same cycle, S2 loads the new result. When S1 advances and a new input is accepted in the same cycle, S1 loads the new input. No loss or duplication.
- acc_clr is ignored for ops other than 12.

Test Plan:
- Reset then LANES=4, op 0, a=0x01FF_7F10, b=0x0101_0110, out_ready=1 -> 2 cycles later out_valid=1, c=0x0200_8020 (lane 2 wraps to 0x00, no carry into lane 3).
- Op 8, a=0xF0F0_0A00, b=0x2010_0500 -> c=0xFFFF_0F00. Op 9, same a and b -> c=0xD0E0_0500. Op 9, a=0x05, b=0x09 (lane 0) -> 0x00.
- Op 6, b lanes = {8,3,0,1}, a = 0x01 in all lanes -> c lanes {0x00,0x08,0x01,0x02}. Op 7, b=9 -> lane result 0.
- MAC: 4 back-to-back op 12 transactions, a=b=0x10 in all lanes, acc_clr=1 on the first only -> acc lanes 0x100, 0x200, 0x300, 0x400; c lane = 0x00 each. Next op 12 with acc_clr=1, a=b=3 -> acc=9, c=0x09.
- Backpressure: out_ready=0 for 5 cycles while streaming 3 transactions -> in_ready drops after S1 and S2 fill. c/acc are held stable. On release, results emerge in order with no loss or duplicates, and each MAC accumulates exactly once.
- Async reset pulse mid-stream with both stages full -> out_valid=0, c=0, acc=0 immediately. The first post-reset MAC with acc_clr=0, a=b=2 gives acc=4.
